ddma_mem_arbiter: RTL and testbench
===================================

# ddma_mem_arbiter

Round-robin arbiter and sequencer for the single memory port shared by the send (TX, memory read) and receive (RX, memory write) engines of the double DMA. It grants the port in bursts, muxes the owner's address and data onto the memory bus, and returns read data to the send engine. A burst-length cap bounds how long either side can wait. It sits between the two DMA engines and the memory interface, inside the DMA.

## Interface
- MEMORY_BUS_WIDTH, 32: data width of the memory bus.
- ADDR_WIDTH, 32: memory address width.
- MAX_BURST, 16: maximum beats per grant; must be ≥1.

- clock  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- tx_req  in  1  send engine requests/holds the port
- tx_addr  in  ADDR_WIDTH  read address for the current beat
- tx_last  in  1  current TX beat is the final beat of its burst
- tx_gnt  out  1  TX owns the port
- tx_rdata  out  MEMORY_BUS_WIDTH  read data; equals mem_rdata
- tx_rvalid  out  1  tx_rdata is valid
- rx_req  in  1  receive engine requests/holds the port
- rx_addr  in  ADDR_WIDTH  write address
- rx_wdata  in  MEMORY_BUS_WIDTH  write data
- rx_last  in  1  final RX beat
- rx_gnt  out  1  RX owns the port
- mem_en  out  1  memory access this cycle
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  MEMORY_BUS_WIDTH  memory write data
- mem_rdata  in  MEMORY_BUS_WIDTH  read data, valid one cycle after the read access
- owner  out  1  last/current owner: 0 = TX, 1 = RX (debug)

## Operation
- States: ARB_IDLE, ARB_TX, ARB_RX.
  - tx_gnt = (state == ARB_TX).
  - rx_gnt = (state == ARB_RX).
- Beat: the cycle the granted engine has req = 1.
  - mem_en = 1 and the memory signals are muxed from the owner in that cycle.
  - mem_we = 1 for RX, 0 for TX.
- Outside a beat: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Granted engine drops req without last: grant is held, no beat occurs (stall) and beat_cnt is unchanged.
- beat_cnt is $clog2(MAX_BURST+1) bits, cleared on every grant change.
  - Release occurs on a beat with last = 1, or on a beat with beat_cnt == MAX_BURST-1 (forced).
- Next owner at release or in ARB_IDLE, using last_owner (the owner that held the port most recently):
  - Both requesting: grant the engine that is not last_owner.
  - One requesting: grant that engine.
  - None requesting: go to ARB_IDLE.
  - At release, last_owner becomes the releasing engine first, so a waiting peer always wins.
  - A sole requester is re-granted immediately.
- owner reflects last_owner in ARB_IDLE and the current grantee otherwise.
- tx_rvalid is registered: 1 exactly one cycle after each TX beat.
- tx_rdata = mem_rdata, combinational.

## Timing
- Reset values: state = ARB_IDLE, last_owner = RX (so TX wins the first tie), beat_cnt = 0, tx_rvalid = 0.
  - All gnt and mem_* outputs are 0; owner = 1.
- Grant latency: req rising in ARB_IDLE → gnt high the next cycle. The first beat can occur in that cycle.
- Handoff: release at cycle N → new gnt at N+1, with zero dead cycles. Old gnt is low at N+1.
- Read latency: TX beat at N → tx_rvalid and tx_rdata at N+1. This holds even if the grant switched at N+1.
- Reset asserted mid-burst: at the next edge all state returns to reset values and the burst is abandoned. The engines restart.
- MAX_BURST = 1: every beat releases.

## Structure
- Package ddma_pkg contains:
  - typedef enum logic [1:0] mem_arb_state_t {ARB_IDLE, ARB_TX, ARB_RX}
  - typedef enum logic mem_owner_t {OWN_TX = 0, OWN_RX = 1}
- Sub-module rr_pick2: combinational 2-way round-robin pick.
  - Inputs: req[1:0], last_owner.
  - Outputs: pick and any.
  - Used both in ARB_IDLE and at release.

## Test plan
- After reset, tx_req and rx_req both rise at cycle 2 → tx_gnt = 1 at cycle 3. TX does 3 beats with last on beat 3 → rx_gnt = 1 the next cycle with no gap; owner goes 0 → 1.
- MAX_BURST = 4, rx_req held with last never set, tx_req = 1 → RX forced off after 4 writes, TX granted the next cycle. After a 1-beat TX burst, RX regains the port.
- TX reads addr 0x10, mem_rdata = 0xDEADBEEF the next cycle → tx_rvalid = 1 for exactly that cycle with tx_rdata = 0xDEADBEEF. mem_we = 0 during the beat.
- RX granted, rx_req drops for 3 cycles mid-burst → rx_gnt stays 1, mem_en = 0 during the gap, and beat_cnt is unchanged. Resumed beats continue the count.
- Sole requester TX issues back-to-back single-beat bursts → tx_gnt stays continuously 1 and a beat occurs every cycle.
- reset asserted during the 2nd beat of an RX burst → the next cycle shows rx_gnt = 0, mem_en = 0, owner = 1. With both requesting after reset, TX is granted first.

Source files
------------

// File: rtl/ddma_mem_arbiter_pkg.sv
// ddma_pkg: shared types for the DMA memory-port arbiter.
package ddma_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_TX, ARB_RX} mem_arb_state_t;
    typedef enum logic {OWN_TX = 1'b0, OWN_RX = 1'b1} mem_owner_t;
    function automatic mem_owner_t other_owner(input mem_owner_t o);
        return o == OWN_TX ? OWN_RX : OWN_TX;
    endfunction
endpackage

// File: rtl/ddma_mem_arbiter_if.sv
// ddma_mem_arbiter_if: engine-side and memory-side signals of the shared memory port.
interface ddma_mem_arbiter_if #(
    parameter int ADDR_WIDTH       = 32,
    parameter int MEMORY_BUS_WIDTH = 32
);
    logic                        tx_req, tx_last, tx_gnt, tx_rvalid;
    logic                        rx_req, rx_last, rx_gnt;
    logic                        mem_en, mem_we, owner;
    logic [ADDR_WIDTH-1:0]       tx_addr, rx_addr, mem_addr;
    logic [MEMORY_BUS_WIDTH-1:0] tx_rdata, rx_wdata, mem_wdata, mem_rdata;
    modport master (
        output tx_req, tx_addr, tx_last, rx_req, rx_addr, rx_wdata, rx_last, mem_rdata,
        input  tx_gnt, tx_rdata, tx_rvalid, rx_gnt, mem_en, mem_we, mem_addr, mem_wdata, owner
    );
    modport slave (
        input  tx_req, tx_addr, tx_last, rx_req, rx_addr, rx_wdata, rx_last, mem_rdata,
        output tx_gnt, tx_rdata, tx_rvalid, rx_gnt, mem_en, mem_we, mem_addr, mem_wdata, owner
    );
endinterface

// File: rtl/ddma_mem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick; on a tie the engine that is not last_owner wins.
module rr_pick2
    import ddma_pkg::*;
(
    input  logic [1:0] req,
    input  mem_owner_t last_owner,
    output mem_owner_t pick,
    output logic       any
);
    assign any  = |req;
    assign pick = &req ? other_owner(last_owner) : (req[1] ? OWN_RX : OWN_TX);
endmodule

// File: rtl/ddma_mem_arbiter.sv
// ddma_mem_arbiter: burst-capped round-robin owner of the single DMA memory port.
module ddma_mem_arbiter
    import ddma_pkg::*;
#(
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int MAX_BURST        = 16
) (
    input logic              clock,
    input logic              reset,
    ddma_mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);
    mem_arb_state_t state, nxt;
    mem_owner_t     last_owner, cur, pick, ref_owner;
    logic [CW-1:0]  beat_cnt;
    logic           any, tx_beat, rx_beat, beat, rel, tx_rvalid_q;
    assign tx_beat = state == ARB_TX && bus.tx_req;
    assign rx_beat = state == ARB_RX && bus.rx_req;
    assign beat    = tx_beat | rx_beat;
    assign cur     = state == ARB_RX ? OWN_RX : OWN_TX;
    assign rel     = beat && ((tx_beat ? bus.tx_last : bus.rx_last) || beat_cnt == CAP);
    // The releasing engine counts as last owner so a waiting peer takes the port.
    assign ref_owner = rel ? cur : last_owner;
    rr_pick2 u_pick (
        .req       ({bus.rx_req, bus.tx_req}),
        .last_owner(ref_owner),
        .pick      (pick),
        .any       (any)
    );
    assign nxt = !any ? ARB_IDLE : (pick == OWN_RX ? ARB_RX : ARB_TX);
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ARB_IDLE;
            last_owner  <= OWN_RX;
            beat_cnt    <= '0;
            tx_rvalid_q <= 1'b0;
        end else begin
            tx_rvalid_q <= tx_beat;
            if (state == ARB_IDLE) begin
                state <= nxt;
            end else if (rel) begin
                state      <= nxt;
                last_owner <= cur;
                beat_cnt   <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end
    assign bus.tx_gnt    = state == ARB_TX;
    assign bus.rx_gnt    = state == ARB_RX;
    assign bus.owner     = state == ARB_IDLE ? last_owner : cur;
    assign bus.mem_en    = beat;
    assign bus.mem_we    = rx_beat;
    assign bus.mem_addr  = tx_beat ? bus.tx_addr : (rx_beat ? bus.rx_addr : {ADDR_WIDTH{1'b0}});
    assign bus.mem_wdata = rx_beat ? bus.rx_wdata : {MEMORY_BUS_WIDTH{1'b0}};
    assign bus.tx_rvalid = tx_rvalid_q;
    assign bus.tx_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_ddma_mem_arbiter.sv
// tb_ddma_mem_arbiter: directed scenarios with a beat/read-data scoreboard.
module tb_ddma_mem_arbiter;
    import ddma_pkg::*;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;
    ddma_mem_arbiter_if #(.ADDR_WIDTH(32), .MEMORY_BUS_WIDTH(32)) bus ();
    ddma_mem_arbiter #(.MEMORY_BUS_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST(4)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        owner;
    } beat_t;
    beat_t       beat_q[$];
    logic [31:0] rd_q[$];
    int vectors = 0;
    int miscompares = 0;
    // Memory responder: read data one cycle after a read beat.
    always @(posedge clock)
        bus.mem_rdata <= (bus.mem_en === 1'b1 && bus.mem_we === 1'b0)
            ? (bus.mem_addr == 32'h10 ? 32'hDEAD_BEEF : bus.mem_addr ^ 32'h5A5A_0000) : 32'h0;
    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step;
        @(posedge clock);
        #1;
    endtask
    task automatic exp_rd(input logic [31:0] a, input logic [31:0] d);
        beat_q.push_back(beat_t'{1'b0, a, 32'h0, 1'b0});
        rd_q.push_back(d);
    endtask
    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        beat_q.push_back(beat_t'{1'b1, a, d, 1'b1});
    endtask
    initial begin
        beat_t got;
        forever begin
            @(negedge clock);
            got = {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.owner};
            if (bus.mem_en === 1'b1) begin
                if (beat_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL beat_unexpected: got %0h expected no beat", got);
                end else chk("beat", 96'(got), 96'(beat_q.pop_front()));
            end else if (bus.mem_en === 1'b0 && !reset) begin
                chk("bus_quiet", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 96'h0);
            end
            if (bus.tx_rvalid === 1'b1) begin
                if (rd_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rvalid_unexpected: got rdata %0h expected no rvalid", bus.tx_rdata);
                end else chk("rdata", 96'(bus.tx_rdata), 96'(rd_q.pop_front()));
            end
        end
    end
    initial begin
        {bus.tx_req, bus.tx_last, bus.rx_req, bus.rx_last} = '0;
        bus.tx_addr = '0;
        bus.rx_addr = '0;
        bus.rx_wdata = '0;
        step;
        step;
        #1 chk("reset_state", {bus.tx_gnt, bus.rx_gnt, bus.owner, bus.mem_en, bus.tx_rvalid}, 96'b00100);
        reset = 1'b0;
        step;
        bus.tx_req = 1; bus.rx_req = 1; bus.tx_addr = 32'h100; bus.tx_last = 0;
        bus.rx_addr = 32'h200; bus.rx_wdata = 32'h1111_1111; bus.rx_last = 1;
        #1 chk("idle_no_gnt_yet", {bus.tx_gnt, bus.rx_gnt}, 96'b00);
        step;
        #1 chk("tie_tx_first", {bus.tx_gnt, bus.rx_gnt, bus.owner}, 96'b100);
        exp_rd(32'h100, 32'h5A5A_0100);
        step; bus.tx_addr = 32'h104; exp_rd(32'h104, 32'h5A5A_0104);
        step; bus.tx_addr = 32'h108; bus.tx_last = 1; exp_rd(32'h108, 32'h5A5A_0108);
        step;
        #1 chk("handoff_rx", {bus.tx_gnt, bus.rx_gnt, bus.owner}, 96'b011);
        exp_wr(32'h200, 32'h1111_1111);
        step; bus.tx_addr = 32'h10; bus.rx_req = 0;
        #1 chk("read_we", {bus.tx_gnt, bus.owner, bus.mem_en, bus.mem_we}, 96'b1010);
        exp_rd(32'h10, 32'hDEAD_BEEF);
        step; bus.tx_addr = 32'h20; exp_rd(32'h20, 32'h5A5A_0020);
        #1 chk("b2b_gnt0", {bus.tx_gnt, bus.mem_en}, 96'b11);
        step; bus.tx_addr = 32'h24; exp_rd(32'h24, 32'h5A5A_0024);
        #1 chk("b2b_gnt1", {bus.tx_gnt, bus.mem_en}, 96'b11);
        step; bus.tx_addr = 32'h28; exp_rd(32'h28, 32'h5A5A_0028);
        #1 chk("b2b_gnt2", {bus.tx_gnt, bus.mem_en}, 96'b11);
        step; bus.tx_req = 0;
        #1 chk("tx_stall", {bus.tx_gnt, bus.mem_en}, 96'b10);
        step;
        bus.tx_req = 1; bus.tx_addr = 32'h30; bus.tx_last = 1;
        bus.rx_req = 1; bus.rx_last = 0; bus.rx_addr = 32'h300; bus.rx_wdata = 32'hA0;
        exp_rd(32'h30, 32'h5A5A_0030);
        step; bus.tx_addr = 32'h40;
        #1 chk("rx_after_tx", {bus.tx_gnt, bus.rx_gnt}, 96'b01);
        exp_wr(32'h300, 32'hA0);
        for (int i = 1; i < 4; i++) begin
            step;
            bus.rx_addr = 32'h300 + 32'(4 * i);
            bus.rx_wdata = 32'hA0 + 32'(i);
            exp_wr(bus.rx_addr, bus.rx_wdata);
        end
        step;
        #1 chk("forced_release_tx", {bus.tx_gnt, bus.rx_gnt}, 96'b10);
        exp_rd(32'h40, 32'h5A5A_0040);
        step; bus.tx_req = 0; bus.rx_addr = 32'h400; bus.rx_wdata = 32'hC0;
        #1 chk("rx_regain", {bus.tx_gnt, bus.rx_gnt}, 96'b01);
        exp_wr(32'h400, 32'hC0);
        for (int i = 0; i < 3; i++) begin
            step; bus.rx_req = 0;
            #1 chk("rx_stall", {bus.rx_gnt, bus.mem_en}, 96'b10);
        end
        step;
        bus.rx_req = 1; bus.rx_addr = 32'h404; bus.rx_wdata = 32'hC1;
        bus.tx_req = 1; bus.tx_addr = 32'h50; bus.tx_last = 1;
        exp_wr(32'h404, 32'hC1);
        step; bus.rx_addr = 32'h408; bus.rx_wdata = 32'hC2; exp_wr(32'h408, 32'hC2);
        #1 chk("rx_cnt_hold0", bus.rx_gnt, 96'b1);
        step; bus.rx_addr = 32'h40C; bus.rx_wdata = 32'hC3; exp_wr(32'h40C, 32'hC3);
        #1 chk("rx_cnt_hold1", bus.rx_gnt, 96'b1);
        step;
        #1 chk("stall_count_kept", {bus.tx_gnt, bus.rx_gnt}, 96'b10);
        exp_rd(32'h50, 32'h5A5A_0050);
        step; bus.rx_addr = 32'h500; bus.rx_wdata = 32'hB0;
        #1 chk("rx_before_reset", bus.rx_gnt, 96'b1);
        exp_wr(32'h500, 32'hB0);
        step; bus.rx_addr = 32'h504; bus.rx_wdata = 32'hB1; reset = 1;
        exp_wr(32'h504, 32'hB1);
        step; reset = 0; bus.tx_addr = 32'h60;
        #1 chk("after_reset", {bus.tx_gnt, bus.rx_gnt, bus.mem_en, bus.owner}, 96'b0001);
        step;
        #1 chk("reset_tie_tx", {bus.tx_gnt, bus.rx_gnt}, 96'b10);
        exp_rd(32'h60, 32'h5A5A_0060);
        step; bus.tx_req = 0; bus.rx_req = 0;
        repeat (3) step;
        chk("beat_q_drained", 96'(beat_q.size()), 96'd0);
        chk("rd_q_drained", 96'(rd_q.size()), 96'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
